wb_mem_responder: RTL and testbench

//  Wishbone classic responder: the slave end of the ZAP CPU bus, answering

---
 rtl/wb_mem_responder.sv | 175 +++++++++++++++++
 tb/tb_wb_mem_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_responder.sv
// Wishbone classic slave answering DRAM and BIOS ROM cycles from a
// req/ready backing memory, with programmable wait states on first beats.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for cyc & stb to a decoded address
// S_WAIT | counting wait states before the memory request
// S_REQ  | mem_req held until mem_ready completes the access
// S_ACK  | one-cycle bus acknowledge (suppressed if the master left)
module wb_mem_responder #(
  parameter logic [31:0] DRAM_BASE   = 32'h0000_0000,
  parameter int          DRAM_AW     = 19,
  parameter logic [31:0] ROM_BASE    = 32'h0300_0000,
  parameter int          ROM_AW      = 18,
  parameter int          MEM_AW      = 19,
  parameter int          WAIT_STATES = 2
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic [31:0]       i_wb_adr,
  input  logic [31:0]       i_wb_dat,
  input  logic [3:0]        i_wb_sel,
  input  logic [2:0]        i_wb_cti,
  output logic [31:0]       o_wb_dat,
  output logic              o_wb_ack,
  output logic              o_hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_rom,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQ, S_ACK} state_t;

  localparam int         DRAM_SH   = DRAM_AW + 2;
  localparam int         ROM_SH    = ROM_AW + 2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              in_burst_q, in_burst_d;
  logic              drop_q, drop_d;
  logic              we_q, we_d;
  logic              rom_q, rom_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdat_q, rdat_d;

  logic              hit_dram, hit_rom, accept;
  logic [MEM_AW-1:0] off_dram, off_rom;
  logic              adr_unused;

  // Regions are size-aligned, so decode is an upper-bit compare and the
  // word offset is simply the low address bits above the byte lane.
  assign hit_dram   = (i_wb_adr[31:DRAM_SH] == DRAM_BASE[31:DRAM_SH]);
  assign hit_rom    = (i_wb_adr[31:ROM_SH] == ROM_BASE[31:ROM_SH]);
  assign off_dram   = MEM_AW'(i_wb_adr[DRAM_SH-1:2]);
  assign off_rom    = MEM_AW'(i_wb_adr[ROM_SH-1:2]);
  assign o_hit      = hit_dram | hit_rom;
  assign adr_unused = ^i_wb_adr[1:0];
  assign accept     = (state_q == S_IDLE) && i_wb_cyc && i_wb_stb && o_hit;

  // Next-state and datapath capture for the access sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_burst_d = in_burst_q;
    drop_d     = drop_q;
    we_d       = we_q;
    rom_d      = rom_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rdat_d     = rdat_q;
    case (state_q)
      S_IDLE: begin
        if (!i_wb_cyc) in_burst_d = 1'b0;
        if (accept) begin
          rom_d   = !hit_dram;
          addr_d  = hit_dram ? off_dram : off_rom;
          we_d    = i_wb_we && hit_dram;
          be_d    = i_wb_sel;
          wdata_d = i_wb_dat;
          cnt_d   = WAIT_INIT;
          drop_d  = 1'b0;
          if (i_wb_cti == 3'b010)
            in_burst_d = 1'b1;
          else if ((i_wb_cti == 3'b000) || (i_wb_cti == 3'b111))
            in_burst_d = 1'b0;
          // ROM writes are discarded but still acknowledged.
          if (i_wb_we && !hit_dram)
            state_d = S_ACK;
          else if ((WAIT_STATES != 0) && !in_burst_q)
            state_d = S_WAIT;
          else
            state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (!i_wb_cyc) begin
          state_d    = S_IDLE;
          in_burst_d = 1'b0;
        end else if (cnt_q <= 4'd1) begin
          state_d = S_REQ;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_REQ: begin
        // Once the memory sees the request the access must finish; a master
        // that left meanwhile just does not get acknowledged.
        if (!i_wb_cyc) drop_d = 1'b1;
        if (mem_ready) begin
          if (i_wb_cyc && !drop_q) begin
            state_d = S_ACK;
            if (!we_q) rdat_d = mem_rdata;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and captured-access registers.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      in_burst_q <= 1'b0;
      drop_q     <= 1'b0;
      we_q       <= 1'b0;
      rom_q      <= 1'b0;
      addr_q     <= '0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      rdat_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_burst_q <= in_burst_d;
      drop_q     <= drop_d;
      we_q       <= we_d;
      rom_q      <= rom_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rdat_q     <= rdat_d;
    end
  end

  assign o_wb_ack  = (state_q == S_ACK);
  assign mem_req   = (state_q == S_REQ);
  assign o_wb_dat  = rdat_q;
  assign mem_we    = we_q;
  assign mem_rom   = rom_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench for wb_mem_responder (WAIT_STATES=2, default regions).
module tb_wb_mem_responder;
  localparam int MEM_AW = 19;

  logic              sys_clk, reset_n;
  logic              i_wb_cyc, i_wb_stb, i_wb_we;
  logic [31:0]       i_wb_adr, i_wb_dat;
  logic [3:0]        i_wb_sel;
  logic [2:0]        i_wb_cti;
  logic [31:0]       o_wb_dat;
  logic              o_wb_ack, o_hit;
  logic              mem_req, mem_we, mem_rom;
  logic [MEM_AW-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata, mem_rdata;
  logic              mem_ready;

  wb_mem_responder #(.WAIT_STATES(2)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
    .i_wb_cti(i_wb_cti), .o_wb_dat(o_wb_dat), .o_wb_ack(o_wb_ack),
    .o_hit(o_hit), .mem_req(mem_req), .mem_we(mem_we), .mem_rom(mem_rom),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;

  logic              obs_req, obs_rom, obs_we;
  logic [MEM_AW-1:0] obs_addr;
  logic [3:0]        obs_be;
  logic [31:0]       obs_wdata;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rdata;
    int          rdly;
    logic        exp_hit;
    int          exp_lat;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_rom;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus beat, driven from a negedge; lat = cycle ack first seen, 0 if none.
  task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                      input logic [3:0] sel, input logic [2:0] cti,
                      input logic [31:0] rdata, input int rdly, input bit keep_cyc,
                      input int budget, output int lat, output logic hit);
    int req_cnt;
    req_cnt = 0;
    lat = 0;
    obs_req = 1'b0;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
    i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel; i_wb_cti = cti;
    mem_rdata = rdata;
    mem_ready = (rdly == 0);
    #1 hit = o_hit;
    for (int n = 1; n <= budget; n++) begin
      @(posedge sys_clk); @(negedge sys_clk);
      if (mem_req) begin
        if (!obs_req) begin
          obs_addr = mem_addr; obs_rom = mem_rom; obs_we = mem_we;
          obs_be = mem_be; obs_wdata = mem_wdata;
        end
        obs_req = 1'b1;
        req_cnt++;
        mem_ready = (req_cnt >= rdly);
      end
      if (o_wb_ack) begin
        lat = n;
        break;
      end
    end
    i_wb_stb = 1'b0; i_wb_we = 1'b0; i_wb_cyc = keep_cyc;
    mem_ready = 1'b0;
    if (lat != 0) begin
      @(posedge sys_clk); @(negedge sys_clk);
      chk("ack_single", {31'd0, o_wb_ack}, 32'd0);
    end
    if (!keep_cyc) begin
      @(posedge sys_clk); @(negedge sys_clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   lat;
    logic hit;
    bit   seen_req, seen_ack;
    logic [31:0] dat_before;

    //            adr            we    dat           sel    rdata         rdly hit   lat req   addr        rom   we    be     dat
    tbl[0]  = '{32'h0000_0010, 1'b0, 32'h0,        4'hF, 32'hCAFE_F00D, 0, 1'b1, 4, 1'b1, 32'h4,     1'b0, 1'b0, 4'hF, 32'hCAFE_F00D};
    tbl[1]  = '{32'h0000_0100, 1'b1, 32'h1234_5678, 4'h3, 32'hDEAD_BEEF, 0, 1'b1, 4, 1'b1, 32'h40,    1'b0, 1'b1, 4'h3, 32'hCAFE_F00D};
    tbl[2]  = '{32'h0300_0008, 1'b1, 32'h1111_2222, 4'hF, 32'hDEAD_BEEF, 0, 1'b1, 1, 1'b0, 32'h0,     1'b0, 1'b0, 4'h0, 32'hCAFE_F00D};
    tbl[3]  = '{32'h0300_0010, 1'b0, 32'h0,        4'hF, 32'hB105_0001, 0, 1'b1, 4, 1'b1, 32'h4,     1'b1, 1'b0, 4'hF, 32'hB105_0001};
    tbl[4]  = '{32'h0340_0000, 1'b0, 32'h0,        4'hF, 32'h7777_7777, 0, 1'b0, 0, 1'b0, 32'h0,     1'b0, 1'b0, 4'h0, 32'hB105_0001};
    tbl[5]  = '{32'h001F_FFFC, 1'b0, 32'h0,        4'hF, 32'h5A5A_A5A5, 0, 1'b1, 4, 1'b1, 32'h7FFFF, 1'b0, 1'b0, 4'hF, 32'h5A5A_A5A5};
    tbl[6]  = '{32'h030F_FFFC, 1'b0, 32'h0,        4'h8, 32'h0BAD_F00D, 0, 1'b1, 4, 1'b1, 32'h3FFFF, 1'b1, 1'b0, 4'h8, 32'h0BAD_F00D};
    tbl[7]  = '{32'h0020_0000, 1'b0, 32'h0,        4'hF, 32'h7777_7777, 0, 1'b0, 0, 1'b0, 32'h0,     1'b0, 1'b0, 4'h0, 32'h0BAD_F00D};
    tbl[8]  = '{32'h0000_0044, 1'b0, 32'h0,        4'hF, 32'h600D_0044, 3, 1'b1, 6, 1'b1, 32'h11,    1'b0, 1'b0, 4'hF, 32'h600D_0044};
    tbl[9]  = '{32'h0000_0013, 1'b0, 32'h0,        4'hF, 32'h1357_9BDF, 0, 1'b1, 4, 1'b1, 32'h4,     1'b0, 1'b0, 4'hF, 32'h1357_9BDF};
    tbl[10] = '{32'h0310_0000, 1'b1, 32'hFFFF_0000, 4'hF, 32'h0,        0, 1'b0, 0, 1'b0, 32'h0,     1'b0, 1'b0, 4'h0, 32'h1357_9BDF};

    reset_n = 1'b0;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    i_wb_adr = 32'h0; i_wb_dat = 32'h0; i_wb_sel = 4'h0; i_wb_cti = 3'b000;
    mem_rdata = 32'h0; mem_ready = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_ack",   {31'd0, o_wb_ack}, 32'd0);
    chk("rst_dat",   o_wb_dat, 32'd0);
    chk("rst_req",   {31'd0, mem_req}, 32'd0);
    chk("rst_we",    {31'd0, mem_we}, 32'd0);
    chk("rst_rom",   {31'd0, mem_rom}, 32'd0);
    chk("rst_addr",  {13'd0, mem_addr}, 32'd0);
    chk("rst_be",    {28'd0, mem_be}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    reset_n = 1'b1;
    @(negedge sys_clk);

    for (int i = 0; i < 11; i++) begin
      xfer(tbl[i].adr, tbl[i].we, tbl[i].dat, tbl[i].sel, 3'b000, tbl[i].rdata,
           tbl[i].rdly, 1'b0, 12, lat, hit);
      chk($sformatf("v%0d_hit", i), {31'd0, hit}, {31'd0, tbl[i].exp_hit});
      chk($sformatf("v%0d_lat", i), lat, tbl[i].exp_lat);
      chk($sformatf("v%0d_req", i), {31'd0, obs_req}, {31'd0, tbl[i].exp_req});
      if (tbl[i].exp_req) begin
        chk($sformatf("v%0d_addr", i), {13'd0, obs_addr}, tbl[i].exp_addr);
        chk($sformatf("v%0d_rom", i), {31'd0, obs_rom}, {31'd0, tbl[i].exp_rom});
        chk($sformatf("v%0d_we", i), {31'd0, obs_we}, {31'd0, tbl[i].exp_we});
        chk($sformatf("v%0d_be", i), {28'd0, obs_be}, {28'd0, tbl[i].exp_be});
        if (tbl[i].we) chk($sformatf("v%0d_wdata", i), obs_wdata, tbl[i].dat);
      end
      chk($sformatf("v%0d_dat", i), o_wb_dat, tbl[i].exp_dat);
    end

    // Incrementing burst: only the first beat pays the wait states.
    for (int i = 0; i < 4; i++) begin
      xfer(32'h20 + 32'(4 * i), 1'b0, 32'h0, 4'hF, (i == 3) ? 3'b111 : 3'b010,
           32'hB000_0000 + 32'(i), 0, (i != 3), 12, lat, hit);
      chk($sformatf("burst%0d_lat", i), lat, (i == 0) ? 32'd4 : 32'd2);
      chk($sformatf("burst%0d_addr", i), {13'd0, obs_addr}, 32'h8 + 32'(i));
      chk($sformatf("burst%0d_dat", i), o_wb_dat, 32'hB000_0000 + 32'(i));
    end

    // Burst cut short by dropping cyc: next classic beat waits again.
    xfer(32'h60, 1'b0, 32'h0, 4'hF, 3'b010, 32'hC0, 0, 1'b1, 12, lat, hit);
    chk("bcut0_lat", lat, 32'd4);
    xfer(32'h64, 1'b0, 32'h0, 4'hF, 3'b010, 32'hC1, 0, 1'b0, 12, lat, hit);
    chk("bcut1_lat", lat, 32'd2);
    xfer(32'h68, 1'b0, 32'h0, 4'hF, 3'b000, 32'hC2, 0, 1'b0, 12, lat, hit);
    chk("bcut2_lat", lat, 32'd4);

    // Abort during WAIT.
    dat_before = o_wb_dat;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_adr = 32'h50;
    i_wb_sel = 4'hF; i_wb_cti = 3'b010; mem_ready = 1'b1; mem_rdata = 32'hABAD_0050;
    @(posedge sys_clk); @(negedge sys_clk);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    seen_req = 1'b0; seen_ack = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge sys_clk); @(negedge sys_clk);
      seen_req |= mem_req;
      seen_ack |= o_wb_ack;
    end
    chk("abort_req", {31'd0, seen_req}, 32'd0);
    chk("abort_ack", {31'd0, seen_ack}, 32'd0);
    chk("abort_dat", o_wb_dat, dat_before);
    mem_ready = 1'b0;
    xfer(32'h54, 1'b0, 32'h0, 4'hF, 3'b000, 32'hD054, 0, 1'b0, 12, lat, hit);
    chk("post_abort_lat", lat, 32'd4);

    // cyc drops while in REQ: access still completes, ack suppressed.
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_adr = 32'h70; i_wb_cti = 3'b000;
    mem_ready = 1'b0; mem_rdata = 32'hE070;
    seen_req = 1'b0;
    for (int n = 0; n < 10 && !seen_req; n++) begin
      @(posedge sys_clk); @(negedge sys_clk);
      seen_req = mem_req;
    end
    chk("drop_req_seen", {31'd0, seen_req}, 32'd1);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    @(posedge sys_clk); @(negedge sys_clk);
    chk("drop_req_held", {31'd0, mem_req}, 32'd1);
    mem_ready = 1'b1;
    seen_ack = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(posedge sys_clk); @(negedge sys_clk);
      seen_ack |= o_wb_ack;
    end
    chk("drop_ack", {31'd0, seen_ack}, 32'd0);
    chk("drop_req_done", {31'd0, mem_req}, 32'd0);
    mem_ready = 1'b0;

    // Reset asserted while in REQ.
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_adr = 32'h74; i_wb_sel = 4'h6;
    i_wb_we = 1'b1; i_wb_dat = 32'h9876_5432;
    seen_req = 1'b0;
    for (int n = 0; n < 10 && !seen_req; n++) begin
      @(posedge sys_clk); @(negedge sys_clk);
      seen_req = mem_req;
    end
    chk("rreq_req_seen", {31'd0, seen_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rreq_req",   {31'd0, mem_req}, 32'd0);
    chk("rreq_ack",   {31'd0, o_wb_ack}, 32'd0);
    chk("rreq_dat",   o_wb_dat, 32'd0);
    chk("rreq_addr",  {13'd0, mem_addr}, 32'd0);
    chk("rreq_be",    {28'd0, mem_be}, 32'd0);
    chk("rreq_wdata", mem_wdata, 32'd0);
    chk("rreq_we",    {31'd0, mem_we}, 32'd0);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    @(negedge sys_clk);
    reset_n = 1'b1;
    seen_ack = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge sys_clk); @(negedge sys_clk);
      seen_ack |= o_wb_ack;
    end
    chk("post_rst_ack", {31'd0, seen_ack}, 32'd0);
    xfer(32'h78, 1'b0, 32'h0, 4'hF, 3'b000, 32'hF00D_0078, 0, 1'b0, 12, lat, hit);
    chk("post_rst_lat", lat, 32'd4);
    chk("post_rst_dat", o_wb_dat, 32'hF00D_0078);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
